// File: rtl/neuron_activate.sv
// Accumulates saturating 4-bit partial sums into one neuron and presents the activated result.
// Latency 1 cycle from the final term to m_valid; s_ready is low while a result waits on m_ready.
// Default build uses a step activation; define NEURON_RELU_EN for a biased ReLU.
module neuron_activate #(
    parameter int ACC_W     = 8,
    parameter int THRESH    = 10,
    parameter int MAX_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [3:0]       s_sum,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_o,
    output logic             m_sat,
    output logic [3:0]       m_cnt
);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    localparam logic [ACC_W:0]   ACC_MAX = {1'b0, {ACC_W{1'b1}}};
    localparam logic [ACC_W-1:0] THR     = ACC_W'(THRESH);
    localparam logic [3:0]       MAXT    = 4'(MAX_TERMS);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               s_ready_q, s_ready_d;
    logic [ACC_W-1:0]   m_o_q, m_o_d;
    logic               m_sat_q, m_sat_d;
    logic [3:0]         m_cnt_q, m_cnt_d;

    logic [ACC_W:0]     sum_ext;
    logic               clamp;
    logic [ACC_W-1:0]   acc_new;
    logic [3:0]         cnt_new;
    logic               xfer;
    logic               done;

    function automatic logic [ACC_W-1:0] activate(input logic [ACC_W-1:0] a);
`ifdef NEURON_RELU_EN
        return (a > THR) ? (a - THR) : '0;
`else
        return {{(ACC_W-1){1'b0}}, (a >= THR)};
`endif
    endfunction

    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, s_sum};
        clamp   = (sum_ext > ACC_MAX);
        acc_new = clamp ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
        cnt_new = cnt_q + 4'd1;
        xfer    = s_valid && s_ready_q;
        done    = s_last || (cnt_new == MAXT);

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        m_o_d   = m_o_q;
        m_sat_d = m_sat_q;
        m_cnt_d = m_cnt_q;

        case (state_q)
            ST_ACC: begin
                if (xfer) begin
                    acc_d = acc_new;
                    cnt_d = cnt_new;
                    sat_d = sat_q || clamp;
                    if (done) begin
                        state_d = ST_OUT;
                        m_o_d   = activate(acc_new);
                        m_sat_d = sat_q || clamp;
                        m_cnt_d = cnt_new;
                    end
                end
            end
            ST_OUT: begin
                // Result registers hold until the handshake; the next neuron starts clean.
                if (m_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase

        s_ready_d = (state_d == ST_ACC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            s_ready_q <= 1'b0;
            m_o_q     <= '0;
            m_sat_q   <= 1'b0;
            m_cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            s_ready_q <= s_ready_d;
            m_o_q     <= m_o_d;
            m_sat_q   <= m_sat_d;
            m_cnt_q   <= m_cnt_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = (state_q == ST_OUT);
    assign m_o     = m_o_q;
    assign m_sat   = m_sat_q;
    assign m_cnt   = m_cnt_q;

endmodule
